// File: rtl/draw_bg_modes_if.sv
// -----------------------------------------------------------------------------
// VGA bus interfaces used around the draw pipeline.
//   vga_if_no_rgb : timing only (hcount/vcount [10:0], hsync, vsync, hblnk, vblnk)
//                   bg_in modport consumes it, out modport produces it.
//   vga_if        : timing plus rgb [11:0]
//                   in modport consumes it, out modport produces it.
// -----------------------------------------------------------------------------
interface vga_if_no_rgb;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;

    modport bg_in (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport out   (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_bg_modes.sv
// -----------------------------------------------------------------------------
// draw_bg_modes
// Four-mode background generator (IDLE, SINGLE, MULTI, PAUSE) placed right
// after the VGA timing generator. Screen changes happen on frame boundaries;
// any change into or out of IDLE fades through black one level per
// FRAMES_PER_STEP frames.
//
// Ports:
//   clk65MHz    in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   mode_req    in   [1:0] requested screen (0 IDLE, 1 SINGLE, 2 MULTI, 3 PAUSE)
//   timing_if   in   raw VGA timing (no colour)
//   draw_bg_if  out  timing delayed by two clocks plus rgb [11:0]
//   mode_active out  [1:0] screen currently drawn
//   busy        out  high while a fade is in progress
//   fsm_state   out  [1:0] fade FSM state (0 SHOW, 1 FADE_OUT, 2 FADE_IN)
// -----------------------------------------------------------------------------
module draw_bg_modes #(
    parameter int HOR_PIX         = 1024,
    parameter int VER_PIX         = 768,
    parameter int BAR_TOP         = 51,
    parameter int BAR_BOT         = 50,
    parameter int NET_X           = 512,
    parameter int NET_W           = 12,
    parameter int DASH_LEN        = 16,
    parameter int PANEL_X         = 80,
    parameter int PANEL_W         = 863,
    parameter int PANEL_Y         = 80,
    parameter int PANEL_H         = 607,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic         clk65MHz,
    input  logic         rst_n,
    input  logic [1:0]   mode_req,
    vga_if_no_rgb.bg_in  timing_if,
    vga_if.out           draw_bg_if,
    output logic [1:0]   mode_active,
    output logic         busy,
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_MULTI = 2'd2;
    localparam logic [1:0] M_PAUSE = 2'd3;

    localparam logic [10:0] H_LAST    = 11'(HOR_PIX - 1);
    localparam logic [10:0] V_LAST    = 11'(VER_PIX - 1);
    localparam logic [10:0] TOP_END   = 11'(BAR_TOP);
    localparam logic [10:0] BOT_START = 11'(VER_PIX - BAR_BOT);
    localparam logic [10:0] NET_LO    = 11'(NET_X);
    localparam logic [10:0] NET_HI    = 11'(NET_X + NET_W);
    localparam logic [10:0] DASH      = 11'(DASH_LEN);
    localparam logic [10:0] PX_LO     = 11'(PANEL_X);
    localparam logic [10:0] PX_HI     = 11'(PANEL_X + PANEL_W);
    localparam logic [10:0] PY_LO     = 11'(PANEL_Y);
    localparam logic [10:0] PY_HI     = 11'(PANEL_Y + PANEL_H);
    localparam logic [7:0]  F_LAST    = 8'(FRAMES_PER_STEP - 1);

    localparam logic [11:0] C_YEL = 12'hff0;
    localparam logic [11:0] C_RED = 12'hf00;
    localparam logic [11:0] C_GRN = 12'h0f0;
    localparam logic [11:0] C_BLU = 12'h00f;
    localparam logic [11:0] C_GRY = 12'h555;
    localparam logic [11:0] C_WHT = 12'hfff;
    localparam logic [11:0] C_BG  = 12'h02f;

    state_t     state;
    logic [2:0] level;
    logic [7:0] fcnt;
    logic       vblnk_d;
    logic       frame_evt;
    logic       wrap;

    assign frame_evt = timing_if.vblnk & ~vblnk_d;
    assign wrap      = (fcnt == F_LAST);
    assign fsm_state = state;

    // ---------------- fade / mode FSM (advances on frame events only) -------
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SHOW;
            level       <= 3'd0;
            fcnt        <= 8'd0;
            mode_active <= M_IDLE;
            busy        <= 1'b0;
            vblnk_d     <= 1'b0;
        end else begin
            vblnk_d <= timing_if.vblnk;
            if (frame_evt) begin
                case (state)
                    SHOW: begin
                        if (mode_req != mode_active) begin
                            // Game-to-game switches are instant; IDLE is
                            // always entered/left through black.
                            if (mode_req != M_IDLE && mode_active != M_IDLE) begin
                                mode_active <= mode_req;
                            end else begin
                                state <= FADE_OUT;
                                fcnt  <= 8'd0;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    FADE_OUT: begin
                        if (!wrap) begin
                            fcnt <= fcnt + 8'd1;
                        end else begin
                            fcnt <= 8'd0;
                            if (mode_req == mode_active) begin
                                // Request withdrawn: fade back in from here.
                                state <= FADE_IN;
                            end else if (level == 3'd3) begin
                                // Screen is black for the whole next step,
                                // so the swap is invisible.
                                level       <= 3'd4;
                                mode_active <= mode_req;
                                state       <= FADE_IN;
                            end else begin
                                level <= level + 3'd1;
                            end
                        end
                    end
                    FADE_IN: begin
                        if (!wrap) begin
                            fcnt <= fcnt + 8'd1;
                        end else begin
                            fcnt <= 8'd0;
                            if (level <= 3'd1) begin
                                level <= 3'd0;
                                state <= SHOW;
                                busy  <= 1'b0;
                            end else begin
                                level <= level - 3'd1;
                            end
                        end
                    end
                    default: state <= SHOW;
                endcase
            end
        end
    end

    // ---------------- raw colour -------------------------------------------
    logic        in_bar;
    logic        in_net;
    logic        dash_odd;
    logic        in_panel;
    logic [11:0] raw_rgb;
    logic [2:0]  level_eff;

    assign in_bar   = (timing_if.vcount < TOP_END) || (timing_if.vcount >= BOT_START);
    assign in_net   = (timing_if.hcount >= NET_LO) && (timing_if.hcount < NET_HI);
    assign dash_odd = ((timing_if.vcount / DASH) % 11'd2) != 11'd0;
    assign in_panel = (timing_if.hcount >= PX_LO) && (timing_if.hcount < PX_HI) &&
                      (timing_if.vcount >= PY_LO) && (timing_if.vcount < PY_HI);

    always_comb begin
        raw_rgb   = 12'h000;
        level_eff = level;
        if (!(timing_if.hblnk || timing_if.vblnk)) begin
            case (mode_active)
                M_IDLE: begin
                    if (timing_if.vcount == 11'd0)        raw_rgb = C_YEL;
                    else if (timing_if.vcount == V_LAST)  raw_rgb = C_RED;
                    else if (timing_if.hcount == 11'd0)   raw_rgb = C_GRN;
                    else if (timing_if.hcount == H_LAST)  raw_rgb = C_BLU;
                    else if (in_panel)                    raw_rgb = C_GRY;
                    else                                  raw_rgb = C_BG;
                end
                M_MULTI: raw_rgb = (in_bar || (in_net && !dash_odd)) ? C_WHT : C_BG;
                default: raw_rgb = (in_bar || in_net) ? C_WHT : C_BG;
            endcase
        end
        // PAUSE dims the SINGLE picture by one extra level, never past black.
        if (mode_active == M_PAUSE && level != 3'd4) begin
            level_eff = level + 3'd1;
        end
    end

    // ---------------- stage 1: raw colour + timing --------------------------
    logic [10:0] s1_hcount;
    logic [10:0] s1_vcount;
    logic        s1_hsync;
    logic        s1_vsync;
    logic        s1_hblnk;
    logic        s1_vblnk;
    logic [11:0] s1_rgb;
    logic [2:0]  s1_shift;

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1_hcount <= 11'd0;
            s1_vcount <= 11'd0;
            s1_hsync  <= 1'b0;
            s1_vsync  <= 1'b0;
            s1_hblnk  <= 1'b0;
            s1_vblnk  <= 1'b0;
            s1_rgb    <= 12'h000;
            s1_shift  <= 3'd0;
        end else begin
            s1_hcount <= timing_if.hcount;
            s1_vcount <= timing_if.vcount;
            s1_hsync  <= timing_if.hsync;
            s1_vsync  <= timing_if.vsync;
            s1_hblnk  <= timing_if.hblnk;
            s1_vblnk  <= timing_if.vblnk;
            s1_rgb    <= raw_rgb;
            s1_shift  <= level_eff;
        end
    end

    // ---------------- stage 2: per-channel fade shift -----------------------
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            draw_bg_if.hcount <= 11'd0;
            draw_bg_if.vcount <= 11'd0;
            draw_bg_if.hsync  <= 1'b0;
            draw_bg_if.vsync  <= 1'b0;
            draw_bg_if.hblnk  <= 1'b0;
            draw_bg_if.vblnk  <= 1'b0;
            draw_bg_if.rgb    <= 12'h000;
        end else begin
            draw_bg_if.hcount <= s1_hcount;
            draw_bg_if.vcount <= s1_vcount;
            draw_bg_if.hsync  <= s1_hsync;
            draw_bg_if.vsync  <= s1_vsync;
            draw_bg_if.hblnk  <= s1_hblnk;
            draw_bg_if.vblnk  <= s1_vblnk;
            draw_bg_if.rgb    <= {s1_rgb[11:8] >> s1_shift,
                                  s1_rgb[7:4]  >> s1_shift,
                                  s1_rgb[3:0]  >> s1_shift};
        end
    end

endmodule

// File: tb/tb_draw_bg_modes.sv
// -----------------------------------------------------------------------------
// tb_draw_bg_modes
// Drives short synthetic "frames" (a vblnk pulse followed by a list of probe
// pixels) and checks every output cycle against a queue of expected words
// built from a colour/fade model of the screen modes.
// -----------------------------------------------------------------------------
module tb_draw_bg_modes;

    localparam int W  = 38;
    localparam int NP = 20;

    // ---------------- clock / reset ----------------
    logic       clk65MHz = 1'b0;
    logic       rst_n;
    logic [1:0] mode_req;
    logic [1:0] mode_active;
    logic       busy;
    logic [1:0] fsm_state;

    always #5 clk65MHz = ~clk65MHz;

    vga_if_no_rgb tim ();
    vga_if        bg ();

    draw_bg_modes dut (
        .clk65MHz    (clk65MHz),
        .rst_n       (rst_n),
        .mode_req    (mode_req),
        .timing_if   (tim),
        .draw_bg_if  (bg),
        .mode_active (mode_active),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int           n_vec = 0;
    int           n_err = 0;
    int           exp_mode = 0;
    int           exp_lvl = 0;
    logic [W-1:0] exp_q[$];

    int px_h[NP] = '{0, 1023, 5, 0, 100, 200, 512, 512, 5, 523,
                     524, 5, 5, 5, 5, 80, 79, 942, 943, 300};
    int px_v[NP] = '{0, 5, 767, 5, 100, 300, 60, 64, 10, 64,
                     700, 718, 717, 50, 51, 80, 80, 686, 686, 300};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Screen colour as described for each mode, then the fade shift.
    function automatic logic [11:0] ref_rgb(input int mode, input int lvl,
                                            input int h, input int v,
                                            input bit hb, input bit vb);
        logic [11:0] base;
        int          eff;
        bit          bar;
        bit          net;
        if (hb || vb) return 12'h000;
        bar = (v < 51) || (v >= 718);
        net = (h >= 512) && (h < 524);
        if (mode == 0) begin
            if (v == 0)         base = 12'hff0;
            else if (v == 767)  base = 12'hf00;
            else if (h == 0)    base = 12'h0f0;
            else if (h == 1023) base = 12'h00f;
            else if (h >= 80 && h < 943 && v >= 80 && v < 687) base = 12'h555;
            else                base = 12'h02f;
        end else begin
            if (mode == 2) net = net && (((v / 16) % 2) == 0);
            base = (bar || net) ? 12'hfff : 12'h02f;
        end
        eff = lvl + ((mode == 3) ? 1 : 0);
        if (eff > 4) eff = 4;
        return {base[11:8] >> eff, base[7:4] >> eff, base[3:0] >> eff};
    endfunction

    // One clock of stimulus: check the output due now, then drive and queue.
    task automatic cyc(input int h, input int v, input bit hs, input bit vs,
                       input bit hb, input bit vb);
        logic [W-1:0] e;
        @(negedge clk65MHz);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check_val("timing", {bg.hcount, bg.vcount, bg.hsync, bg.vsync, bg.hblnk, bg.vblnk},
                      e[W-1:12]);
            check_val("rgb", bg.rgb, e[11:0]);
        end
        tim.hcount = 11'(h);
        tim.vcount = 11'(v);
        tim.hsync  = hs;
        tim.vsync  = vs;
        tim.hblnk  = hb;
        tim.vblnk  = vb;
        exp_q.push_back({11'(h), 11'(v), hs, vs, hb, vb,
                         ref_rgb(exp_mode, exp_lvl, h, v, hb, vb)});
    endtask

    task automatic pixels();
        // mode_req wiggles between frame events; it must not matter.
        mode_req = 2'($urandom_range(0, 3));
        for (int i = 0; i < NP; i++) begin
            cyc(px_h[i], px_v[i], (i == NP - 1), 1'b0, (i == NP - 1), 1'b0);
        end
    endtask

    task automatic run_frame(input int req, input int e_mode, input int e_lvl, input int e_busy);
        mode_req = 2'(req);
        cyc(0, 768, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(0, 769, 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("mode_active", mode_active, e_mode);
        check_val("busy", busy, e_busy);
        exp_mode = e_mode;
        exp_lvl  = e_lvl;
        pixels();
    endtask

    // Level after the n-th frame event of a full fade (n=1 starts it).
    function automatic int fade_lvl(input int n);
        if (n >= 33) return 0;
        if (n <= 20) return (n - 1) / 4;
        return 4 - (n - 17) / 4;
    endfunction

    // Level after the n-th event of a fade aborted during level 2.
    function automatic int abort_lvl(input int n);
        if (n <= 12) return (n - 1) / 4;
        if (n <= 16) return 2;
        if (n <= 20) return 1;
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_out"}, {bg.hcount, bg.vcount, bg.hsync, bg.vsync, bg.hblnk,
                                  bg.vblnk, bg.rgb}, '0);
        check_val({tag, "_mode"}, mode_active, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_state"}, fsm_state, 0);
    endtask

    // Reset asserted between clock edges; effects must be immediate.
    task automatic reset_mid_line();
        @(negedge clk65MHz);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        exp_q.delete();
        exp_mode = 0;
        exp_lvl  = 0;
        repeat (3) begin
            @(negedge clk65MHz);
            tim.hcount = 11'd0;
            tim.vcount = 11'd0;
            tim.hblnk  = 1'b0;
            tim.vblnk  = 1'b0;
            mode_req   = 2'd2;
            check_val("rst_hold_rgb", bg.rgb, 0);
        end
        @(negedge clk65MHz);
        rst_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n      = 1'b0;
        mode_req   = 2'd0;
        tim.hcount = 11'd300;
        tim.vcount = 11'd200;
        tim.hsync  = 1'b0;
        tim.vsync  = 1'b0;
        tim.hblnk  = 1'b0;
        tim.vblnk  = 1'b0;
        repeat (3) @(negedge clk65MHz);
        check_all_zero("rst_init");
        rst_n = 1'b1;

        // IDLE picture.
        run_frame(0, 0, 0, 0);

        // IDLE -> SINGLE full fade through black.
        for (int n = 1; n <= 34; n++) begin
            run_frame(1, (n >= 17) ? 1 : 0, fade_lvl(n), (n <= 32) ? 1 : 0);
        end

        // Instant switches between game screens.
        run_frame(2, 2, 0, 0);
        run_frame(3, 3, 0, 0);
        run_frame(1, 1, 0, 0);

        // SINGLE -> IDLE, interrupted by reset during the fade-in.
        for (int n = 1; n <= 22; n++) begin
            run_frame(0, (n >= 17) ? 0 : 1, fade_lvl(n), 1);
        end
        reset_mid_line();
        run_frame(0, 0, 0, 0);

        // IDLE -> MULTI, withdrawn at level 2.
        for (int n = 1; n <= 22; n++) begin
            run_frame((n <= 10) ? 2 : 0, 0, abort_lvl(n), (n <= 20) ? 1 : 0);
        end

        cyc(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
